// File: rtl/hss_prt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hss_prt_pkg
// Description : Shared widths, default timing constants and FSM state encoding
//               for the HSS register-port initiator.
// Revision    : 1.0
// ============================================================================
package hss_prt_pkg;

    localparam int HSS_PRT_ADDR_W    = 11;
    localparam int HSS_PRT_DATA_W    = 16;

    localparam int HSS_PRT_SETUP_CYC = 2;
    localparam int HSS_PRT_AEN_CYC   = 4;
    localparam int HSS_PRT_HOLD_CYC  = 2;
    localparam int HSS_PRT_RD_LAT    = 8;
    localparam int HSS_PRT_TIMEOUT   = 1023;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_WAIT_RD = 3'd4,
        ST_RESP    = 3'd5
    } hss_prt_state_e;

    function automatic int hss_prt_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hss_prt_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : hss_prt_initiator_if
// Description : Request/response handshake bundle between a requester and the
//               HSS register-port initiator.
// Revision    : 1.0
// ============================================================================
interface hss_prt_initiator_if;
    import hss_prt_pkg::*;

    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [HSS_PRT_ADDR_W-1:0] req_addr;
    logic [HSS_PRT_DATA_W-1:0] req_wdata;
    logic                      rsp_valid;
    logic [HSS_PRT_DATA_W-1:0] rsp_rdata;
    logic                      rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface
`default_nettype wire

// File: rtl/hss_sync2.sv
`default_nettype none
// ============================================================================
// Module      : hss_sync2
// Description : Parameterized-width two-flop synchronizer, async reset to 0.
// Revision    : 1.0
// ============================================================================
module hss_sync2 #(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/hss_prt_initiator.sv
`default_nettype none
// ============================================================================
// Module      : hss_prt_initiator
// Description : Sequences single read/write requests onto the HSSPRT pins with
//               fixed setup/strobe/hold windows and a fixed read latency.
//               Optional request timeout: HSS_PRT_TIMEOUT_EN.
// Revision    : 1.0
// ============================================================================
module hss_prt_initiator
    import hss_prt_pkg::*;
#(
    parameter int SETUP_CYC = HSS_PRT_SETUP_CYC,
    parameter int AEN_CYC   = HSS_PRT_AEN_CYC,
    parameter int HOLD_CYC  = HSS_PRT_HOLD_CYC,
    parameter int RD_LAT    = HSS_PRT_RD_LAT,
    parameter int TIMEOUT   = HSS_PRT_TIMEOUT
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    hss_prt_initiator_if.slave             bus,
    output logic                           link_up,
    input  wire logic                      HSSPLLLOCKA,
    input  wire logic                      HSSPLLLOCKB,
    input  wire logic                      HSSPRTREADYA,
    input  wire logic                      HSSPRTREADYB,
    output logic [HSS_PRT_ADDR_W-1:0]      HSSPRTADDR,
    output logic [HSS_PRT_DATA_W-1:0]      HSSPRTDATAIN,
    output logic                           HSSPRTWRITE,
    output logic                           HSSPRTAEN,
    input  wire logic [HSS_PRT_DATA_W-1:0] HSSPRTDATAOUT
);

    localparam int c_CNT_MAX = hss_prt_max(hss_prt_max(hss_prt_max(SETUP_CYC, AEN_CYC),
                                                       hss_prt_max(HOLD_CYC, RD_LAT)),
                                           TIMEOUT);
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    logic [3:0]                w_status_sync;
    logic                      r_link_up;
    hss_prt_state_e            r_state;
    hss_prt_state_e            w_next;
    logic [c_CNT_W-1:0]        r_cnt;
    logic                      w_ready;
    logic                      w_accept;
    logic                      w_to_hit;
    logic [HSS_PRT_ADDR_W-1:0] r_addr;
    logic [HSS_PRT_DATA_W-1:0] r_wdata;
    logic                      r_write;
    logic                      r_err;
    logic [HSS_PRT_DATA_W-1:0] r_rdata;

    hss_sync2 #(
        .WIDTH (4)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d ({HSSPLLLOCKA, HSSPLLLOCKB, HSSPRTREADYA, HSSPRTREADYB}),
        .o_q (w_status_sync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_link_up <= 1'b0;
        end else begin
            r_link_up <= &w_status_sync;
        end
    end

`ifdef HSS_PRT_TIMEOUT_EN
    logic [c_CNT_W-1:0] r_to_cnt;

    // Counts only while a request is stalled purely by a down link.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if ((r_state != ST_IDLE) || !bus.req_valid || r_link_up) begin
            r_to_cnt <= '0;
        end else if (!w_to_hit) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_to_hit = (r_to_cnt == c_CNT_W'(TIMEOUT));
`else
    assign w_to_hit = 1'b0;
`endif

    assign w_ready  = (r_state == ST_IDLE) && (r_link_up || w_to_hit);
    assign w_accept = w_ready && bus.req_valid;

    function automatic logic [c_CNT_W-1:0] f_load(input hss_prt_state_e s);
        case (s)
            ST_SETUP:   f_load = c_CNT_W'(SETUP_CYC - 1);
            ST_STROBE:  f_load = c_CNT_W'(AEN_CYC - 1);
            ST_HOLD:    f_load = c_CNT_W'(HOLD_CYC - 1);
            ST_WAIT_RD: f_load = c_CNT_W'(RD_LAT - 1);
            default:    f_load = '0;
        endcase
    endfunction

    // State register and the shared dwell counter, reloaded on every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= f_load(w_next);
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = r_link_up ? ST_SETUP : ST_RESP;
                end
            end
            ST_SETUP: begin
                if (r_cnt == '0) w_next = ST_STROBE;
            end
            ST_STROBE: begin
                if (r_cnt == '0) w_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (r_cnt == '0) w_next = r_write ? ST_RESP : ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                if (r_cnt == '0) w_next = ST_RESP;
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Pin values are latched only for a real transaction; a timed-out request
    // leaves the macro interface untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_err   <= !r_link_up;
                r_rdata <= '0;
                if (r_link_up) begin
                    r_addr  <= bus.req_addr;
                    r_wdata <= bus.req_wdata;
                    r_write <= bus.req_write;
                end
            end else begin
                if ((r_state != ST_IDLE) && (r_state != ST_RESP) && !r_link_up) begin
                    r_err <= 1'b1;
                end
                if ((r_state == ST_WAIT_RD) && (r_cnt == '0)) begin
                    r_rdata <= HSSPRTDATAOUT;
                end
            end
        end
    end

    always_comb begin
        bus.req_ready = w_ready;
        bus.rsp_valid = (r_state == ST_RESP);
        bus.rsp_err   = (r_state == ST_RESP) && r_err;
        bus.rsp_rdata = '0;
        if ((r_state == ST_RESP) && !r_write && !r_err) begin
            bus.rsp_rdata = r_rdata;
        end
        HSSPRTAEN     = (r_state == ST_STROBE);
        HSSPRTADDR    = r_addr;
        HSSPRTDATAIN  = r_wdata;
        HSSPRTWRITE   = r_write;
        link_up       = r_link_up;
    end

endmodule
`default_nettype wire

// File: tb/tb_hss_prt_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_hss_prt_initiator
// Description : Scoreboard bench for hss_prt_initiator with a small register
//               model on the HSSPRT pins. Timeout case under HSS_PRT_TIMEOUT_EN.
// Revision    : 1.0
// ============================================================================
module tb_hss_prt_initiator;

    localparam int c_WR_LAT = 1 + 2 + 4 + 2;
    localparam int c_RD_LAT = c_WR_LAT + 8;

    logic        clk;
    logic        rst;
    logic        link_up;
    logic        lock_a, lock_b, rdy_a, rdy_b;
    logic [10:0] prt_addr;
    logic [15:0] prt_din;
    logic        prt_write;
    logic        prt_aen;
    logic [15:0] prt_dout;
    logic [15:0] mem [0:2047];
    int          cyc;
    int          n_vec;
    int          n_bad;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q_exp[$];

    hss_prt_initiator_if bus ();

    hss_prt_initiator #(
        .SETUP_CYC (2),
        .AEN_CYC   (4),
        .HOLD_CYC  (2),
        .RD_LAT    (8),
        .TIMEOUT   (20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .link_up       (link_up),
        .HSSPLLLOCKA   (lock_a),
        .HSSPLLLOCKB   (lock_b),
        .HSSPRTREADYA  (rdy_a),
        .HSSPRTREADYB  (rdy_b),
        .HSSPRTADDR    (prt_addr),
        .HSSPRTDATAIN  (prt_din),
        .HSSPRTWRITE   (prt_write),
        .HSSPRTAEN     (prt_aen),
        .HSSPRTDATAOUT (prt_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (prt_aen && prt_write) mem[prt_addr] <= prt_din;
    end
    assign prt_dout = mem[prt_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            if (q_exp.size() == 0) begin
                chk("spurious_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
                chk("rsp_err",   32'(bus.rsp_err),   32'(e.err));
                chk("rsp_cycle", 32'(cyc),           32'(e.cyc));
            end
        end
    end

    task automatic do_req(input logic wr, input logic [10:0] a, input logic [15:0] d,
                          input logic [15:0] er, input logic ee, input int raise_at,
                          input int drop_at, input int rst_at, input bit to_path,
                          output int t_start, output int t_acc, output int t_raise);
        bit   got;
        exp_t e;
        got     = 0;
        t_raise = -1;
        t_acc   = -1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        #1;
        t_start = cyc;
        for (int i = 0; i < 60; i++) begin
            if (bus.req_ready) begin
                got = 1;
                break;
            end
            if (i == 0 && raise_at >= 0) chk("gated_ready", 32'(bus.req_ready), 32'd0);
            if (i == raise_at) begin
                lock_b  = 1'b1;
                t_raise = cyc;
            end
            @(negedge clk);
            #1;
        end
        if (!got) begin
            chk("accept_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        t_acc = cyc;
        if (rst_at < 0) begin
            e.rdata = er;
            e.err   = ee;
            e.cyc   = t_acc + (to_path ? 1 : (wr ? c_WR_LAT : c_RD_LAT));
            q_exp.push_back(e);
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            #1;
            if (k == 1) begin
                bus.req_valid = 1'b0;
                bus.req_addr  = ~a;
                bus.req_wdata = ~d;
                bus.req_write = ~wr;
            end
            if (to_path) begin
                chk("to_aen", 32'(prt_aen), 32'd0);
                if (k == 2) return;
            end else begin
                chk("pin_aen",   32'(prt_aen),   32'((k >= 3 && k <= 6) ? 1 : 0));
                chk("pin_addr",  32'(prt_addr),  32'(a));
                chk("pin_din",   32'(prt_din),   32'(d));
                chk("pin_write", 32'(prt_write), 32'(wr));
            end
            if (k == drop_at) rdy_a = 1'b0;
            if (k == rst_at) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_aen",   32'(prt_aen),       32'd0);
                chk("rst_addr",  32'(prt_addr),      32'd0);
                chk("rst_din",   32'(prt_din),       32'd0);
                chk("rst_write", 32'(prt_write),     32'd0);
                chk("rst_ready", 32'(bus.req_ready), 32'd0);
                chk("rst_rspv",  32'(bus.rsp_valid), 32'd0);
                chk("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
                chk("rst_err",   32'(bus.rsp_err),   32'd0);
                chk("rst_link",  32'(link_up),       32'd0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q_exp.size() != 0; i++) @(negedge clk);
        if (q_exp.size() != 0) begin
            chk("rsp_missing", 32'(q_exp.size()), 32'd0);
            q_exp.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int ts, ta, tr;
        n_vec = 0;
        n_bad = 0;
        cyc   = 0;
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
        mem[11'h7FF]  = 16'h1234;
        rst           = 1'b1;
        lock_a        = 1'b0;
        lock_b        = 1'b0;
        rdy_a         = 1'b0;
        rdy_b         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(bus.req_ready), 32'd0);
        chk("reset_rspv",  32'(bus.rsp_valid), 32'd0);
        chk("reset_aen",   32'(prt_aen),       32'd0);
        chk("reset_addr",  32'(prt_addr),      32'd0);
        chk("reset_link",  32'(link_up),       32'd0);
        rst = 1'b0;

        lock_a = 1'b1; lock_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
        repeat (5) @(negedge clk);
        chk("link_up", 32'(link_up), 32'd1);

        do_req(1'b1, 11'h155, 16'hA5A5, 16'h0000, 1'b0, -1, -1, -1, 1'b0, ts, ta, tr);
        drain();
        do_req(1'b0, 11'h7FF, 16'h0000, 16'h1234, 1'b0, -1, -1, -1, 1'b0, ts, ta, tr);
        drain();
        do_req(1'b0, 11'h155, 16'hFFFF, 16'hA5A5, 1'b0, -1, -1, -1, 1'b0, ts, ta, tr);
        drain();

        lock_b = 1'b0;
        repeat (5) @(negedge clk);
        chk("link_down", 32'(link_up), 32'd0);
        do_req(1'b1, 11'h0AA, 16'h5A5A, 16'h0000, 1'b0, 4, -1, -1, 1'b0, ts, ta, tr);
        chk("lock_to_accept", 32'(ta - tr), 32'd3);
        drain();

        do_req(1'b0, 11'h7FF, 16'h0000, 16'h0000, 1'b1, -1, 4, -1, 1'b0, ts, ta, tr);
        drain();
        rdy_a = 1'b1;
        do_req(1'b0, 11'h7FF, 16'h0000, 16'h1234, 1'b0, -1, -1, -1, 1'b0, ts, ta, tr);
        drain();

        do_req(1'b0, 11'h7FF, 16'h0000, 16'h0000, 1'b0, -1, -1, 4, 1'b0, ts, ta, tr);
        repeat (20) @(negedge clk);
        do_req(1'b1, 11'h001, 16'hBEEF, 16'h0000, 1'b0, -1, -1, -1, 1'b0, ts, ta, tr);
        drain();
        do_req(1'b0, 11'h001, 16'h0000, 16'hBEEF, 1'b0, -1, -1, -1, 1'b0, ts, ta, tr);
        drain();

`ifdef HSS_PRT_TIMEOUT_EN
        lock_b = 1'b0;
        repeat (5) @(negedge clk);
        do_req(1'b0, 11'h055, 16'h0000, 16'h0000, 1'b1, -1, -1, -1, 1'b1, ts, ta, tr);
        chk("timeout_count", 32'(ta - ts), 32'd20);
        drain();
        lock_b = 1'b1;
        repeat (5) @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hss_prt_initiator.md
# hss_prt_initiator

Register-port initiator driving the HSS macro's HSSPRT control interface from the PCS side. Accepts single read/write requests over a valid/ready handshake and sequences HSSPRTADDR/HSSPRTDATAIN/HSSPRTWRITE/HSSPRTAEN with fixed setup, strobe and hold windows. For reads, it captures HSSPRTDATAOUT after a fixed latency. Requests are gated until both PLLs report lock and both ports report ready.

## Interface
- SETUP_CYC, 2, cycles address/data/write are stable before HSSPRTAEN rises (≥1)
- AEN_CYC, 4, cycles HSSPRTAEN is held high (≥1)
- HOLD_CYC, 2, cycles address/data/write are held after HSSPRTAEN falls (≥1)
- RD_LAT, 8, cycles after hold before HSSPRTDATAOUT is sampled (≥1)
- TIMEOUT, 1023, cycles a request may wait for link_up (only with HSS_PRT_TIMEOUT_EN)

Ports:
- Clk  in  1  block clock
- Rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid is also high
- req_write  in  1  1 = write, 0 = read
- req_addr  in  11  port address
- req_wdata  in  16  write data
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_rdata  out  16  read data; 0 for writes
- rsp_err  out  1  link lost during the transaction, or timeout
- link_up  out  1  synchronized AND of all four HSS status inputs
- HSSPLLLOCKA, HSSPLLLOCKB, HSSPRTREADYA, HSSPRTREADYB  in  1 each  asynchronous status inputs
- HSSPRTADDR  out  11
- HSSPRTDATAIN  out  16
- HSSPRTWRITE  out  1
- HSSPRTAEN  out  1
- HSSPRTDATAOUT  in  16  read data from the macro

## Operation
- Each status bit passes through a 2-flop synchronizer. link_up is registered: link_up = AND of the four synchronized bits.
- req_ready = (state == IDLE) && link_up. It is combinational from registered state.
- States and transitions:
  - IDLE: on accept, latch addr/wdata/write and go to SETUP.
  - SETUP: lasts SETUP_CYC, then STROBE.
  - STROBE: HSSPRTAEN=1 for AEN_CYC, then HOLD.
  - HOLD: lasts HOLD_CYC. A write then goes to RESP; a read goes to WAIT_RD.
  - WAIT_RD: lasts RD_LAT. On its last cycle, register HSSPRTDATAOUT into rsp_rdata. Then RESP.
  - RESP: rsp_valid=1 for one cycle, then IDLE.
- HSSPRTADDR, HSSPRTDATAIN and HSSPRTWRITE are driven from the latched values from SETUP through HOLD. They keep their last values until the next accept.
- A sticky err flag is set if link_up is 0 in any cycle from SETUP to WAIT_RD. Behaviour on link loss:
  - The transaction still runs to completion.
  - rsp_err=1 in RESP.
  - For a read, rsp_rdata is forced to 0.
  - The flag clears on the next accept.
- One counter, 10 bits wide or sized to the largest parameter, is reloaded on each state entry.
- Reset mid-transaction: all state and outputs return to reset values asynchronously, so HSSPRTAEN drops immediately. No response is issued.

## Timing
- Reset values are 0 for all of: HSSPRTADDR, HSSPRTDATAIN, HSSPRTWRITE, HSSPRTAEN, req_ready, rsp_valid, rsp_rdata, rsp_err, link_up. State is IDLE.
- Status-to-link_up latency: 3 cycles (2 synchronizer flops plus the AND register).
- Latency with defaults, measured from accept at cycle T:
  - SETUP runs T+1..T+2.
  - HSSPRTAEN is high T+3..T+6.
  - HOLD runs T+7..T+8.
  - Write: rsp_valid at T+9.
  - Read: WAIT_RD runs T+9..T+16, DATAOUT is sampled at the end of T+16, rsp_valid at T+17.
- General response cycle:
  - Write: T+1+SETUP_CYC+AEN_CYC+HOLD_CYC.
  - Read: the write value plus RD_LAT.
- Back-to-back: the earliest next accept is the cycle after RESP, so req_ready is low during RESP.
- If req_valid drops before accept, nothing happens. Inputs are sampled only in the accept cycle.

## Configuration
- HSS_PRT_TIMEOUT_EN defined:
  - In IDLE with req_valid=1 and link_up=0, a counter increments each cycle and clears when req_valid falls.
  - When the count reaches TIMEOUT, the request is accepted (req_ready=1 for that cycle) and goes directly to RESP with rsp_err=1 and rsp_rdata=0. HSSPRT pins are not touched.
- Undefined: the request waits indefinitely for link_up. The TIMEOUT parameter is unused and no timeout logic exists.

## Structure
- hss_prt_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, HOLD, WAIT_RD, RESP);
  - HSS_PRT_ADDR_W=11 and HSS_PRT_DATA_W=16;
  - the default timing constants.
- Sub-module hss_sync2: a parameterized-width 2-flop synchronizer with async reset, instantiated once at width 4 for the status bits.

## Test plan
- Hold all status bits at 1 for 5 cycles, then write addr 0x155, data 0xA5A5. Expect HSSPRTAEN high for exactly 4 cycles starting at T+3, addr/data stable T+1..T+8, rsp_valid at T+9, rsp_err=0.
- Read addr 0x7FF with the model returning 0x1234. Expect rsp_rdata=0x1234 and rsp_valid at T+17.
- Hold HSSPLLLOCKB low with req_valid held high. Expect req_ready=0. Raise lock; expect accept 3 cycles later.
- Drop HSSPRTREADYA at T+4 of a read. Expect the full sequence, rsp_err=1 and rsp_rdata=0 at T+17. The next transaction gives err=0.
- Assert Rst during STROBE. Expect HSSPRTAEN=0 immediately, no rsp_valid, and all outputs 0.
- With HSS_PRT_TIMEOUT_EN, TIMEOUT=20 and link down, hold req_valid. Expect accept at count 20, rsp_err=1 the next cycle, and HSSPRTAEN never rising.
